// File: rtl/core_pkg.sv
`default_nettype none
// ============================================================================
// Module   : core_pkg
// Purpose  : Shared opcode constants and sequencer state encoding for the
//            simple CPU core control path.
// Revision : 1.0 - initial release
// ============================================================================
package core_pkg;

  // Opcode field values found in ir[7:4]
  localparam logic [3:0] OP_NOP   = 4'h0;
  localparam logic [3:0] OP_SUM   = 4'h1;
  localparam logic [3:0] OP_LOAD  = 4'h2;
  localparam logic [3:0] OP_STORE = 4'h3;
  localparam logic [3:0] OP_HALT  = 4'hF;

  // Sequencer states
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_EXEC   = 3'd3,
    ST_MEM    = 3'd4,
    ST_WB     = 3'd5,
    ST_HALT   = 3'd6
  } state_t;

endpackage
`default_nettype wire

// File: rtl/instr_decoder.sv
`default_nettype none
// ============================================================================
// Module   : instr_decoder
// Purpose  : Combinational opcode classifier; unknown opcodes are flagged
//            illegal and otherwise behave as NOP.
// Revision : 1.0 - initial release
// ============================================================================
module instr_decoder
  import core_pkg::*;
(
  input  logic [3:0] i_opcode,
  output logic       o_is_sum,
  output logic       o_is_load,
  output logic       o_is_store,
  output logic       o_is_halt,
  output logic       o_is_illegal
);

  // One-hot classification of the opcode field
  always_comb begin
    o_is_sum     = 1'b0;
    o_is_load    = 1'b0;
    o_is_store   = 1'b0;
    o_is_halt    = 1'b0;
    o_is_illegal = 1'b0;
    case (i_opcode)
      OP_NOP:   o_is_illegal = 1'b0;
      OP_SUM:   o_is_sum     = 1'b1;
      OP_LOAD:  o_is_load    = 1'b1;
      OP_STORE: o_is_store   = 1'b1;
      OP_HALT:  o_is_halt    = 1'b1;
      default:  o_is_illegal = 1'b1;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/core_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : core_sequencer
// Purpose  : Multi-cycle control sequencer: owns PC and IR, steps each
//            instruction through FETCH/DECODE/EXEC/MEM/WB, drives Sum/Mem
//            enables and aborts to HALT on a memory timeout.
// Revision : 1.0 - initial release
// ============================================================================
module core_sequencer
  import core_pkg::*;
#(
  parameter int PC_W        = 4,
  parameter int PROG_LEN    = 6,
  parameter int MEM_TIMEOUT = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            run_i,
  input  logic [7:0]      instr_i,
  input  logic            mem_ack_i,
  output logic [PC_W-1:0] pc_o,
  output logic [7:0]      ir_o,
  output logic            sum_en_o,
  output logic            load_en_o,
  output logic            store_en_o,
  output logic            mem_req_o,
  output logic            rf_we_o,
  output logic [1:0]      rf_waddr_o,
  output logic            halt_o,
  output logic            illegal_o,
  output logic            timeout_o
);

  localparam int              c_cnt_w    = $clog2(MEM_TIMEOUT + 1);
  // Counter value during the last MEM cycle allowed before abort
  localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(MEM_TIMEOUT - 1);
  localparam logic [PC_W-1:0]    c_pc_last  = PC_W'(PROG_LEN - 1);

  state_t               r_state;
  state_t               w_state_nxt;
  logic [PC_W-1:0]      r_pc;
  logic [7:0]           r_ir;
  logic [c_cnt_w-1:0]   r_cnt;
  logic                 r_illegal;
  logic                 r_timeout;

  logic w_is_sum, w_is_load, w_is_store, w_is_halt, w_is_illegal;
  logic w_end, w_to, w_ir_ld, w_cnt_clr, w_cnt_inc, w_illegal_set;

  instr_decoder u_dec (
    .i_opcode     (r_ir[7:4]),
    .o_is_sum     (w_is_sum),
    .o_is_load    (w_is_load),
    .o_is_store   (w_is_store),
    .o_is_halt    (w_is_halt),
    .o_is_illegal (w_is_illegal)
  );

  // Next-state logic plus Moore enables decoded from state and latched IR
  always_comb begin
    w_state_nxt   = r_state;
    w_end         = 1'b0;
    w_to          = 1'b0;
    w_ir_ld       = 1'b0;
    w_cnt_clr     = 1'b0;
    w_cnt_inc     = 1'b0;
    w_illegal_set = 1'b0;
    sum_en_o      = 1'b0;
    load_en_o     = 1'b0;
    store_en_o    = 1'b0;
    mem_req_o     = 1'b0;
    rf_we_o       = 1'b0;
    halt_o        = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (run_i) w_state_nxt = ST_FETCH;
      end
      ST_FETCH: begin
        w_ir_ld     = 1'b1;
        w_state_nxt = ST_DECODE;
      end
      ST_DECODE: begin
        w_illegal_set = w_is_illegal;
        if (w_is_halt) begin
          w_state_nxt = ST_HALT;
        end else if (w_is_load || w_is_store) begin
          w_state_nxt = ST_MEM;
          w_cnt_clr   = 1'b1;
        end else begin
          w_state_nxt = ST_EXEC;
        end
      end
      ST_EXEC: begin
        sum_en_o = w_is_sum;
        if (w_is_sum) w_state_nxt = ST_WB;
        else          w_end       = 1'b1;
      end
      ST_MEM: begin
        mem_req_o  = 1'b1;
        load_en_o  = w_is_load;
        store_en_o = w_is_store;
        // Ack wins over timeout when both land in the same cycle
        if (mem_ack_i) begin
          if (w_is_load) w_state_nxt = ST_WB;
          else           w_end       = 1'b1;
        end else if (r_cnt == c_cnt_last) begin
          w_to        = 1'b1;
          w_state_nxt = ST_HALT;
        end else begin
          w_cnt_inc = 1'b1;
        end
      end
      ST_WB: begin
        rf_we_o = 1'b1;
        w_end   = 1'b1;
      end
      ST_HALT: begin
        halt_o = 1'b1;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
    // Instruction boundary: run_i decides whether to keep going
    if (w_end) w_state_nxt = run_i ? ST_FETCH : ST_IDLE;
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  // PC, IR, MEM cycle counter and sticky status flags
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc      <= '0;
      r_ir      <= '0;
      r_cnt     <= '0;
      r_illegal <= 1'b0;
      r_timeout <= 1'b0;
    end else begin
      if (w_ir_ld) r_ir <= instr_i;
      if (w_end)   r_pc <= (r_pc == c_pc_last) ? '0 : r_pc + PC_W'(1);
      if (w_cnt_clr)      r_cnt <= '0;
      else if (w_cnt_inc) r_cnt <= r_cnt + c_cnt_w'(1);
      if (w_illegal_set) r_illegal <= 1'b1;
      if (w_to)          r_timeout <= 1'b1;
    end
  end

  assign pc_o       = r_pc;
  assign ir_o       = r_ir;
  assign rf_waddr_o = r_ir[3:2];
  assign illegal_o  = r_illegal;
  assign timeout_o  = r_timeout;

endmodule
`default_nettype wire

// File: tb/tb_core_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_core_sequencer
// Purpose  : Self-checking bench for core_sequencer; an instruction-level
//            model predicts cycle counts, strobe counts and PC/flag results.
// Revision : 1.0 - initial release
// ============================================================================
module tb_core_sequencer;

  localparam int MEM_TO = 8;
  localparam int NEVER  = 99;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       run_i = 1'b0;
  logic       mem_ack_i = 1'b0;
  logic [7:0] instr_i;
  logic [3:0] pc_o;
  logic [7:0] ir_o;
  logic       sum_en_o, load_en_o, store_en_o, mem_req_o, rf_we_o;
  logic [1:0] rf_waddr_o;
  logic       halt_o, illegal_o, timeout_o;

  logic [7:0] prog [0:5];
  int tests = 0;
  int failed = 0;

  // Reference model state
  int m_pc;
  bit m_ill, m_to, m_halt;

  // Per-instruction observations
  int         res_cyc, res_sum, res_ld, res_st, res_req, res_we, res_bad;
  logic [1:0] res_waddr;
  logic [7:0] res_ir;
  logic [3:0] res_pc0;

  core_sequencer #(.PC_W(4), .PROG_LEN(6), .MEM_TIMEOUT(MEM_TO)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .run_i      (run_i),
    .instr_i    (instr_i),
    .mem_ack_i  (mem_ack_i),
    .pc_o       (pc_o),
    .ir_o       (ir_o),
    .sum_en_o   (sum_en_o),
    .load_en_o  (load_en_o),
    .store_en_o (store_en_o),
    .mem_req_o  (mem_req_o),
    .rf_we_o    (rf_we_o),
    .rf_waddr_o (rf_waddr_o),
    .halt_o     (halt_o),
    .illegal_o  (illegal_o),
    .timeout_o  (timeout_o)
  );

  always #5 clk = ~clk;

  // Instruction fetcher: combinational lookup of the program image
  always_comb instr_i = (int'(pc_o) < 6) ? prog[pc_o] : 8'h00;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_pc"},    32'(pc_o), 0);
    chk({tag, "_ir"},    32'(ir_o), 0);
    chk({tag, "_sum"},   32'(sum_en_o), 0);
    chk({tag, "_ld"},    32'(load_en_o), 0);
    chk({tag, "_st"},    32'(store_en_o), 0);
    chk({tag, "_req"},   32'(mem_req_o), 0);
    chk({tag, "_we"},    32'(rf_we_o), 0);
    chk({tag, "_waddr"}, 32'(rf_waddr_o), 0);
    chk({tag, "_halt"},  32'(halt_o), 0);
    chk({tag, "_ill"},   32'(illegal_o), 0);
    chk({tag, "_to"},    32'(timeout_o), 0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0; run_i = 1'b0; mem_ack_i = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    m_pc = 0; m_ill = 0; m_to = 0; m_halt = 0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Leave IDLE: one clock later the sequencer is in its first FETCH
  task automatic start_run();
    run_i = 1'b1;
    @(posedge clk); #1;
  endtask

  // Drive one instruction from its FETCH cycle to PC update (or halt).
  // ack_at: MEM cycle number carrying the ack (NEVER = no ack).
  task automatic exec_one(input int ack_at, input bit drop_run);
    int  req_seen;
    bit  done;
    req_seen = 0; done = 0;
    res_cyc = 0; res_sum = 0; res_ld = 0; res_st = 0; res_req = 0;
    res_we = 0; res_bad = 0; res_waddr = 2'b00; res_ir = 8'h00;
    res_pc0 = pc_o;
    while (!done && res_cyc < 40) begin
      res_cyc++;
      if (res_cyc == 2) res_ir = ir_o;
      if (sum_en_o)   res_sum++;
      if (load_en_o)  res_ld++;
      if (store_en_o) res_st++;
      if (rf_we_o) begin res_we++; res_waddr = rf_waddr_o; end
      if ($countones({sum_en_o, load_en_o, store_en_o}) > 1) res_bad++;
      if (mem_req_o) begin
        res_req++;
        req_seen++;
        if (drop_run) run_i = 1'b0;
      end
      // Outside MEM the ack line carries random noise that must be ignored
      mem_ack_i = mem_req_o ? (req_seen == ack_at) : 1'($urandom_range(0, 1));
      @(posedge clk); #1;
      if (pc_o !== res_pc0 || halt_o === 1'b1) done = 1;
    end
    mem_ack_i = 1'b0;
  endtask

  // Predict the instruction's externally visible behaviour and compare
  task automatic check_instr(input logic [7:0] ins, input int ack_at);
    int op, n, e_cyc, e_sum, e_ld, e_st, e_req, e_we;
    bit to;
    op = int'(ins[7:4]);
    to = (op == 2 || op == 3) && (ack_at > MEM_TO);
    n  = to ? MEM_TO : ack_at;
    e_sum = 0; e_ld = 0; e_st = 0; e_req = 0; e_we = 0;
    case (op)
      0:  e_cyc = 3;
      1:  begin e_cyc = 4; e_sum = 1; e_we = 1; end
      2:  begin e_ld = n; e_req = n; e_cyc = to ? 2 + MEM_TO : 3 + n; e_we = to ? 0 : 1; end
      3:  begin e_st = n; e_req = n; e_cyc = 2 + n; end
      15: begin e_cyc = 2; m_halt = 1; end
      default: begin e_cyc = 3; m_ill = 1; end
    endcase
    if (to) begin m_to = 1; m_halt = 1; end
    chk("pc_at_fetch", 32'(res_pc0), 32'(m_pc));
    chk("ir_latched",  32'(res_ir), 32'(ins));
    chk("cycles",      32'(res_cyc), 32'(e_cyc));
    chk("sum_cycles",  32'(res_sum), 32'(e_sum));
    chk("load_cycles", 32'(res_ld), 32'(e_ld));
    chk("store_cycles",32'(res_st), 32'(e_st));
    chk("req_cycles",  32'(res_req), 32'(e_req));
    chk("we_cycles",   32'(res_we), 32'(e_we));
    chk("enable_onehot", 32'(res_bad), 0);
    if (e_we == 1) chk("waddr", 32'(res_waddr), 32'(ins[3:2]));
    if (!m_halt) m_pc = (m_pc == 5) ? 0 : m_pc + 1;
    chk("pc_after",    32'(pc_o), 32'(m_pc));
    chk("halt",        32'(halt_o), 32'(m_halt));
    chk("illegal",     32'(illegal_o), 32'(m_ill));
    chk("timeout",     32'(timeout_o), 32'(m_to));
  endtask

  function automatic logic [7:0] rand_instr();
    int r;
    logic [3:0] lo;
    r  = $urandom_range(0, 19);
    lo = 4'($urandom_range(0, 15));
    if (r < 3)       return {4'h0, lo};
    else if (r < 8)  return {4'h1, lo};
    else if (r < 12) return {4'h2, lo};
    else if (r < 16) return {4'h3, lo};
    else if (r < 18) return {4'($urandom_range(4, 14)), lo};
    else if (r < 19) return {4'hF, lo};
    else             return {4'h1, lo};
  endfunction

  initial begin
    logic [7:0] ins;
    int         ack;

    // ---- Reset values ----
    foreach (prog[i]) prog[i] = 8'h1B;
    do_reset();
    check_reset_vals("reset");

    // ---- All-SUM program: PC 0..5 then wrap ----
    start_run();
    for (int k = 0; k < 7; k++) begin
      exec_one(1, 1'b0);
      check_instr(8'h1B, 1);
    end

    // ---- LOAD 0x26 with ack on the 3rd MEM cycle ----
    foreach (prog[i]) prog[i] = 8'h26;
    do_reset();
    start_run();
    exec_one(3, 1'b0);
    check_instr(8'h26, 3);

    // ---- STORE 0x3C with no ack: timeout to HALT, PC held at 1 ----
    prog[0] = 8'h00; prog[1] = 8'h3C;
    do_reset();
    start_run();
    exec_one(1, 1'b0);
    check_instr(8'h00, 1);
    exec_one(NEVER, 1'b0);
    check_instr(8'h3C, NEVER);
    // ---- Same STORE with ack on the 8th MEM cycle completes normally ----
    do_reset();
    start_run();
    exec_one(1, 1'b0);
    check_instr(8'h00, 1);
    exec_one(MEM_TO, 1'b0);
    check_instr(8'h3C, MEM_TO);

    // ---- Illegal opcode 0x7 at pc=2 ----
    prog[0] = 8'h00; prog[1] = 8'h1B; prog[2] = 8'h70; prog[3] = 8'h00;
    prog[4] = 8'h00; prog[5] = 8'h00;
    do_reset();
    start_run();
    for (int k = 0; k < 4; k++) begin
      exec_one(1, 1'b0);
      check_instr(prog[m_pc], 1);
    end

    // ---- HALT at pc=3, run_i toggling, then async reset pulse ----
    prog[0] = 8'h1B; prog[1] = 8'h00; prog[2] = 8'h3C; prog[3] = 8'hF0;
    do_reset();
    start_run();
    for (int k = 0; k < 4; k++) begin
      exec_one(2, 1'b0);
      check_instr(prog[m_pc], 2);
    end
    for (int k = 0; k < 6; k++) begin
      run_i = k[0];
      mem_ack_i = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
      chk("halt_sticky", 32'(halt_o), 1);
      chk("halt_pc", 32'(pc_o), 3);
    end
    mem_ack_i = 1'b0;
    #3 rst_n = 1'b0;
    #1 check_reset_vals("async_halt");
    do_reset();

    // ---- run_i dropped during MEM of a LOAD ----
    foreach (prog[i]) prog[i] = 8'h26;
    do_reset();
    start_run();
    exec_one(2, 1'b1);
    check_instr(8'h26, 2);
    for (int k = 0; k < 4; k++) begin
      mem_ack_i = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
      chk("idle_pc_hold", 32'(pc_o), 1);
      chk("idle_no_req", 32'(mem_req_o), 0);
      chk("idle_no_we", 32'(rf_we_o), 0);
    end
    mem_ack_i = 1'b0;
    // ---- Resume at saved pc, then reset during WB ----
    start_run();
    chk("resume_pc", 32'(pc_o), 1);
    for (int k = 0; k < 30 && rf_we_o !== 1'b1; k++) begin
      mem_ack_i = mem_req_o;
      @(posedge clk); #1;
    end
    mem_ack_i = 1'b0;
    chk("wb_reached", 32'(rf_we_o), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("wb_abort_we", 32'(rf_we_o), 0);
    chk("wb_abort_pc", 32'(pc_o), 0);
    run_i = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      chk("post_abort_we", 32'(rf_we_o), 0);
      chk("post_abort_req", 32'(mem_req_o), 0);
    end

    // ---- Randomized programs against the instruction-level model ----
    for (int round = 0; round < 8; round++) begin
      foreach (prog[i]) prog[i] = rand_instr();
      do_reset();
      start_run();
      for (int k = 0; k < 20 && !m_halt; k++) begin
        ins = prog[m_pc];
        ack = ($urandom_range(0, 9) == 0) ? NEVER : int'($urandom_range(1, MEM_TO));
        exec_one(ack, 1'b0);
        check_instr(ins, ack);
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/core_sequencer.md
# core_sequencer

Multi-cycle control sequencer for the simple CPU core. It owns the program counter, latches each 8-bit instruction from the instruction fetcher, and steps it through fetch, decode, execute, memory and writeback states. It drives the sum/load/store enables for the Sum and Mem units and handshakes with memory. It replaces the free-running one-instruction-per-clock PC loop with a sequenced, stallable control path.

## Interface
Parameters:
- PC_W, 4, program counter width
- PROG_LEN, 6, program length; PC wraps to 0 after PROG_LEN-1 (PROG_LEN ≤ 2^PC_W)
- MEM_TIMEOUT, 8, maximum MEM-state cycles without mem_ack_i before abort (≥1)

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  reset, asynchronous, active-low
- run_i  in  1  start/continue; sampled in IDLE and at each instruction boundary
- instr_i  in  8  instruction from fetcher, combinational function of pc_o
- mem_ack_i  in  1  memory completion, sampled only in MEM
- pc_o  out  PC_W  program counter
- ir_o  out  8  latched instruction register
- sum_en_o  out  1  Sum unit enable
- load_en_o  out  1  Mem load enable
- store_en_o  out  1  Mem store enable
- mem_req_o  out  1  memory request
- rf_we_o  out  1  register-file write strobe
- rf_waddr_o  out  2  write address, equals ir_o[3:2]
- halt_o  out  1  in HALT state
- illegal_o  out  1  sticky, undefined opcode seen
- timeout_o  out  1  sticky, memory timeout occurred

## Operation
- Instruction format: opcode ir[7:4], operand A ir[3:2], operand B ir[1:0].
- Opcodes: 0x0 NOP, 0x1 SUM, 0x2 LOAD, 0x3 STORE, 0xF HALT. Any other opcode sets illegal_o and executes as NOP.
- States and transitions:
  - IDLE: go to FETCH when run_i=1.
  - FETCH: ir ← instr_i; go to DECODE.
  - DECODE: SUM or NOP/illegal go to EXEC; LOAD/STORE go to MEM; HALT goes to HALT.
  - EXEC: sum_en_o=1 for SUM only. SUM goes to WB; NOP ends the instruction.
  - MEM: mem_req_o=1, plus load_en_o or store_en_o by opcode, all held until ack. On ack, LOAD goes to WB and STORE ends the instruction.
  - WB: rf_we_o=1 with rf_waddr_o=ir[3:2]; ends the instruction.
  - HALT: halt_o=1; terminal until reset.
- Instruction end: pc ← (pc==PROG_LEN-1) ? 0 : pc+1. Next state is FETCH if run_i=1, otherwise IDLE.
- Memory timeout:
  - A cycle counter of $clog2(MEM_TIMEOUT+1) bits clears on MEM entry.
  - If the MEM_TIMEOUT-th MEM cycle also lacks ack, set timeout_o, drop all enables, go to HALT. PC is not advanced.
  - Ack in that same cycle takes priority over timeout.
- mem_ack_i outside MEM is ignored.
- Enables are Moore outputs decoded from state and ir. At most one of sum/load/store enables is high at a time.

## Timing
- Reset (async assert): state=IDLE; pc_o=0, ir_o=0; every 1-bit output 0; rf_waddr_o=0; sticky flags cleared. Reset asserted mid-instruction aborts it immediately, and no strobes follow deassertion.
- Latency, first cycle of FETCH to PC update, with n = MEM cycles including the ack cycle:
  - NOP: 3 cycles.
  - SUM: 4 cycles.
  - STORE: 2+n cycles.
  - LOAD: 3+n cycles.
- mem_req_o deasserts in the cycle after ack is sampled.
- rf_we_o and sum_en_o are exactly one cycle wide.
- PC wrap: after the instruction at PROG_LEN-1 ends, pc_o=0 in the next FETCH.
- run_i dropped mid-instruction: the current instruction completes, then IDLE. Raising run_i again resumes at the saved pc.

## Structure
- Shared package core_pkg: opcode constants (OP_NOP, OP_SUM, OP_LOAD, OP_STORE, OP_HALT) and the state encoding. The Controller reuses them.
- One sub-module: instr_decoder, combinational ir[7:4] → {is_sum, is_load, is_store, is_halt, is_illegal}.
- Top: state register, PC, IR, timeout counter, sticky flags.

## Test plan
- Reset, run_i=1, program all SUM (0x1B): rf_we_o pulses every 4 cycles with rf_waddr_o=2; pc_o sequence 0..5,0.
- LOAD 0x26 with ack on the 3rd MEM cycle: load_en_o and mem_req_o high for 3 cycles, then rf_we_o one cycle with rf_waddr_o=1. Total 6 cycles.
- STORE 0x3C with ack never: timeout_o=1 after 8 MEM cycles, halt_o=1, pc_o unchanged. Ack on the 8th cycle instead gives normal completion, timeout_o=0.
- Opcode 0x7 at pc=2: illegal_o=1 stays set; pc advances to 3 after 3 cycles; no strobes.
- HALT 0xF0: halt_o=1 and remains 1 with run_i toggling. Async rst_n pulse clears everything to the reset values.
- run_i dropped during MEM of a LOAD, and rst_n asserted mid-WB in a second run:
  - First run: instruction finishes, state goes to IDLE, pc holds.
  - Second run: rf_we_o drops at once and pc_o=0.
